// File: rtl/wb_lfsr_pkg.sv
// Shared definitions for the LFSR Wishbone master: register map, control bits,
// FSM state encoding and a seed byte-lane helper.
package wb_lfsr_pkg;

    localparam logic [2:0] ADDR_SEED0 = 3'd0;
    localparam logic [2:0] ADDR_SEED1 = 3'd1;
    localparam logic [2:0] ADDR_SEED2 = 3'd2;
    localparam logic [2:0] ADDR_SEED3 = 3'd3;
    localparam logic [2:0] ADDR_CTRL  = 3'd4;

    localparam int CTRL_LFSR_RESET = 0;
    localparam int CTRL_LOAD_SEED  = 1;

    localparam logic [7:0] CTRL_WORD_LOAD = (8'd1 << CTRL_LFSR_RESET) | (8'd1 << CTRL_LOAD_SEED);
    localparam logic [7:0] CTRL_WORD_RUN  = 8'h00;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEED      = 3'd1,
        CTRL_LOAD = 3'd2,
        CTRL_RUN  = 3'd3,
        READ      = 3'd4,
        ERR       = 3'd5
    } state_e;

    // Seed byte lane idx goes to seed register idx, least significant first.
    function automatic logic [7:0] seed_byte(input logic [31:0] seed, input logic [1:0] idx);
        return seed[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/wb_lfsr_master_if.sv
// Wishbone classic-pipelined link between the LFSR master and its slave.
interface wb_lfsr_master_if;
    logic       cyc;
    logic       stb;
    logic       we;
    logic [2:0] addr;
    logic [7:0] dat_w;
    logic       stall;
    logic       ack;
    logic       dat_r;

    modport master (output cyc, stb, we, addr, dat_w, input stall, ack, dat_r);
    modport slave  (input cyc, stb, we, addr, dat_w, output stall, ack, dat_r);
endinterface

// File: rtl/wb_lfsr_master_byte_fifo.sv
// Small byte FIFO with simultaneous push/pop; head byte is presented directly.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT = {(AW + 1){1'b0}};

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push_s, do_pop_s;

    // Pointer, occupancy and storage update.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        do_push_s = push & (cnt_q != FULL_CNT);
        do_pop_s  = pop & (cnt_q != ZERO_CNT);
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= ZERO_CNT;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == ZERO_CNT);
    assign count = cnt_q;

endmodule

// File: rtl/wb_lfsr_master.sv
// Wishbone master that seeds and starts the LFSR slave, then reads bits into a byte FIFO.
// Optional bus-timeout detection is enabled by defining WB_LFSR_MASTER_TIMEOUT_EN.
module wb_lfsr_master
    import wb_lfsr_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_seed,
    input  logic [7:0]  i_count,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_err,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    wb_lfsr_master_if.master wb
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] ALMOST_FULL_CNT = CW'(FIFO_DEPTH - 1);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] seed_q, seed_d;
    logic [7:0]  count_q, count_d;
    logic        abort_q, abort_d;
    logic        busy_q, busy_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  dat_q, dat_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  byte_q, byte_d;

    logic          start_s, accept_s, ack_s, abort_s, read_ack_s;
    logic          push_s, pop_s, room_next_s, done_s;
    logic          issue_s, release_s, to_hit_s;
    logic [7:0]    push_data_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_cnt_s;

    // An ack only counts once the request has been (or is being) accepted.
    assign start_s     = (state_q == IDLE) & i_start;
    assign accept_s    = stb_q & ~wb.stall;
    assign ack_s       = cyc_q & wb.ack & ~(stb_q & wb.stall);
    assign abort_s     = abort_q | i_abort;
    assign read_ack_s  = ack_s & (state_q == READ);
    assign push_s      = read_ack_s & (bit_q == 3'd7);
    assign push_data_s = {sr_q[6:0], wb.dat_r};
    assign pop_s       = i_byte_ready & ~fifo_empty_s;
    assign done_s      = push_s & (count_q != 8'd0) & ((byte_q + 8'd1) == count_q);
    // Room for another read once this cycle's push/pop have settled.
    assign room_next_s = ~(fifo_full_s & ~pop_s) &
                         ~(push_s & ~pop_s & (fifo_cnt_s == ALMOST_FULL_CNT));

`ifdef WB_LFSR_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;

    // Ack-wait counter and sticky error flag.
    always_comb begin
        if (cyc_q & ~ack_s) begin
            to_d = to_q + TW'(1);
        end else begin
            to_d = {TW{1'b0}};
        end
        if (state_q == ERR) begin
            err_d = 1'b1;
        end else if (start_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign to_hit_s = cyc_q & ~ack_s & (to_q == TW'(TIMEOUT_CYC - 1));

    // Timeout registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            to_q  <= {TW{1'b0}};
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYC > 0);
    assign to_hit_s         = 1'b0;
    assign o_err            = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; issue_s starts a new beat, release_s drops the bus.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        issue_s   = 1'b0;
        release_s = 1'b0;
        if (to_hit_s) begin
            state_d   = ERR;
            release_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_d = SEED;
                        idx_d   = 2'd0;
                        issue_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SEED, CTRL_LOAD, CTRL_RUN: begin
                    if (!ack_s) begin
                        state_d = state_q;
                    end else if (abort_s) begin
                        state_d   = IDLE;
                        release_s = 1'b1;
                    end else if (state_q == CTRL_RUN) begin
                        state_d   = READ;
                        issue_s   = room_next_s;
                        release_s = ~room_next_s;
                    end else if (state_q == CTRL_LOAD) begin
                        state_d = CTRL_RUN;
                        issue_s = 1'b1;
                    end else if (idx_q == 2'd3) begin
                        state_d = CTRL_LOAD;
                        issue_s = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        issue_s = 1'b1;
                    end
                end
                READ: begin
                    if (cyc_q) begin
                        if (!ack_s) begin
                            state_d = READ;
                        end else if (abort_s | done_s) begin
                            state_d   = IDLE;
                            release_s = 1'b1;
                        end else begin
                            issue_s   = room_next_s;
                            release_s = ~room_next_s;
                        end
                    end else if (abort_s) begin
                        state_d = IDLE;
                    end else begin
                        issue_s = ~fifo_full_s;
                    end
                end
                ERR: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d   = IDLE;
                    release_s = 1'b1;
                end
            endcase
        end
    end

    // Bus output values for the next cycle.
    always_comb begin
        cyc_d  = cyc_q;
        stb_d  = stb_q;
        we_d   = we_q;
        addr_d = addr_q;
        dat_d  = dat_q;
        if (issue_s) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            case (state_d)
                SEED: begin
                    we_d   = 1'b1;
                    addr_d = ADDR_SEED0 | {1'b0, idx_d};
                    dat_d  = seed_byte(seed_d, idx_d);
                end
                CTRL_LOAD: begin
                    we_d   = 1'b1;
                    addr_d = ADDR_CTRL;
                    dat_d  = CTRL_WORD_LOAD;
                end
                CTRL_RUN: begin
                    we_d   = 1'b1;
                    addr_d = ADDR_CTRL;
                    dat_d  = CTRL_WORD_RUN;
                end
                READ: begin
                    we_d   = 1'b0;
                    addr_d = ADDR_SEED0;
                    dat_d  = 8'h00;
                end
                default: begin
                    cyc_d  = 1'b0;
                    stb_d  = 1'b0;
                    we_d   = 1'b0;
                    addr_d = 3'd0;
                    dat_d  = 8'h00;
                end
            endcase
        end else if (release_s) begin
            cyc_d  = 1'b0;
            stb_d  = 1'b0;
            we_d   = 1'b0;
            addr_d = 3'd0;
            dat_d  = 8'h00;
        end else if (accept_s) begin
            stb_d = 1'b0;
        end else begin
            stb_d = stb_q;
        end
    end

    // Seed/count capture, bit shifter and byte counting.
    always_comb begin
        seed_d  = seed_q;
        count_d = count_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        if (start_s) begin
            seed_d  = i_seed;
            count_d = i_count;
            sr_d    = 8'h00;
            bit_d   = 3'd0;
            byte_d  = 8'd0;
        end else if (read_ack_s) begin
            sr_d = push_data_s;
            if (push_s) begin
                bit_d  = 3'd0;
                byte_d = byte_q + 8'd1;
            end else begin
                bit_d = bit_q + 3'd1;
            end
        end else begin
            sr_d = sr_q;
        end
        // A partial byte never survives a return to IDLE.
        if (state_d == IDLE) begin
            bit_d = 3'd0;
        end else begin
            bit_d = bit_d;
        end
        abort_d = (state_q != IDLE) & (state_d != IDLE) & abort_s;
        busy_d  = (state_d != IDLE);
    end

    // Datapath and bus output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            seed_q  <= 32'h0000_0000;
            count_q <= 8'd0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 3'd0;
            dat_q   <= 8'h00;
            sr_q    <= 8'h00;
            bit_q   <= 3'd0;
            byte_q  <= 8'd0;
        end else begin
            seed_q  <= seed_d;
            count_q <= count_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .push  (push_s),
        .din   (push_data_s),
        .pop   (pop_s),
        .dout  (o_byte),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_cnt_s)
    );

    assign o_byte_valid = ~fifo_empty_s;
    assign o_busy       = busy_q;
    assign wb.cyc       = cyc_q;
    assign wb.stb       = stb_q;
    assign wb.we        = we_q;
    assign wb.addr      = addr_q;
    assign wb.dat_w     = dat_q;

endmodule

// File: tb/tb_wb_lfsr_master.sv
// Directed self-checking bench for wb_lfsr_master with a behavioural Wishbone slave.
module tb_wb_lfsr_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start, abort, ready;
    logic [31:0] seed;
    logic [7:0]  count;
    logic        busy, err, valid;
    logic [7:0]  byte_o;

    wb_lfsr_master_if wb();

    wb_lfsr_master #(.FIFO_DEPTH(4), .TIMEOUT_CYC(15)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_seed       (seed),
        .i_count      (count),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_err        (err),
        .o_byte       (byte_o),
        .o_byte_valid (valid),
        .i_byte_ready (ready),
        .wb           (wb)
    );

    always #5 clk = ~clk;

    // Slave model state: read bits come from rd_pat, MSB first, restarting at rd_base.
    int          rd_cnt = 0, rd_base = 0, rd_ack_num = 0, rd_addr_bad = 0;
    int          stall_cnt = 0, stall_arm = 0, stall_unstable = 0;
    bit          no_ack = 1'b0;
    logic        stall_prev = 1'b0;
    logic [2:0]  st_addr = 3'd0;
    logic [7:0]  st_data = 8'h00;
    logic [31:0] rd_pat = 32'hB42D_E17C;
    logic [2:0]  wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    assign wb.stall = wb.cyc & wb.stb & (stall_cnt < stall_arm);

    // Slave responder: stalls on request, records writes, acks one cycle after accept.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.ack     <= 1'b0;
            wb.dat_r   <= 1'b0;
            stall_prev <= 1'b0;
        end else begin
            wb.ack <= 1'b0;
            if (wb.cyc && wb.stb && wb.stall) begin
                stall_cnt  <= stall_cnt + 1;
                stall_prev <= 1'b1;
                if (!stall_prev) begin
                    st_addr <= wb.addr;
                    st_data <= wb.dat_w;
                end else if (wb.addr != st_addr || wb.dat_w != st_data) begin
                    stall_unstable <= stall_unstable + 1;
                end
            end else begin
                stall_prev <= 1'b0;
                if (wb.cyc && wb.stb) begin
                    if (wb.we) begin
                        wr_addr_q.push_back(wb.addr);
                        wr_data_q.push_back(wb.dat_w);
                    end else begin
                        if (wb.addr != 3'd0) rd_addr_bad <= rd_addr_bad + 1;
                        wb.dat_r   <= rd_pat[31 - ((rd_cnt - rd_base) % 32)];
                        rd_ack_num <= rd_cnt - rd_base + 1;
                        rd_cnt     <= rd_cnt + 1;
                    end
                    wb.ack <= !no_ack;
                end
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] s, input logic [7:0] c);
        seed  = s;
        count = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check_eq({tag, "_valid"}, {31'd0, valid}, 32'd1);
        check_eq(tag, {24'd0, byte_o}, {24'd0, exp});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    logic [2:0] exp_a [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [7:0] exp_d [6] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h03, 8'h00};
    int wr_base, stall_base, n, cyc_hi;

    initial begin
        start = 1'b0; abort = 1'b0; ready = 1'b0; seed = 32'd0; count = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_byte", {24'd0, byte_o}, 32'd0);
        check_eq("rst_cyc", {31'd0, wb.cyc}, 32'd0);
        check_eq("rst_stb", {31'd0, wb.stb}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sequence: six writes then eight reads forming one byte.
        rd_base = rd_cnt; wr_base = wr_addr_q.size();
        start_run(32'hDEAD_BEEF, 8'd1);
        wait_idle("t1_idle", 200);
        check_eq("t1_reads", rd_cnt - rd_base, 32'd8);
        check_eq("t1_writes", wr_addr_q.size() - wr_base, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t1_wa%0d", i), {29'd0, wr_addr_q[wr_base + i]}, {29'd0, exp_a[i]});
            check_eq($sformatf("t1_wd%0d", i), {24'd0, wr_data_q[wr_base + i]}, {24'd0, exp_d[i]});
        end
        check_eq("t1_cyc", {31'd0, wb.cyc}, 32'd0);
        check_eq("t1_err", {31'd0, err}, 32'd0);
        check_eq("t1_rdaddr", rd_addr_bad, 32'd0);
        pop_expect("t1_byte", 8'hB4);
        check_eq("t1_empty", {31'd0, valid}, 32'd0);

        // Stall on the first seed write for three cycles.
        rd_base = rd_cnt; wr_base = wr_addr_q.size(); stall_base = stall_cnt;
        stall_arm = stall_cnt + 3;
        start_run(32'h1234_5678, 8'd1);
        wait_idle("t3_idle", 200);
        check_eq("t3_stalls", stall_cnt - stall_base, 32'd3);
        check_eq("t3_stable", stall_unstable, 32'd0);
        check_eq("t3_writes", wr_addr_q.size() - wr_base, 32'd6);
        check_eq("t3_wd0", {24'd0, wr_data_q[wr_base]}, 32'h78);
        check_eq("t3_wd3", {24'd0, wr_data_q[wr_base + 3]}, 32'h12);
        pop_expect("t3_byte", 8'hB4);

        // Back-pressure: continuous mode fills the FIFO and stops reading.
        rd_base = rd_cnt;
        start_run(32'hCAFE_F00D, 8'd0);
        n = 0;
        while ((rd_cnt - rd_base) < 32 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check_eq("t2_reads32", rd_cnt - rd_base, 32'd32);
        check_eq("t2_stb", {31'd0, wb.stb}, 32'd0);
        check_eq("t2_cyc", {31'd0, wb.cyc}, 32'd0);
        check_eq("t2_busy", {31'd0, busy}, 32'd1);
        pop_expect("t2_head0", 8'hB4);
        repeat (40) @(negedge clk);
        check_eq("t2_reads40", rd_cnt - rd_base, 32'd40);
        check_eq("t2_stb2", {31'd0, wb.stb}, 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t2_abort_idle", {31'd0, busy}, 32'd0);
        pop_expect("t2_head1", 8'h2D);
        pop_expect("t2_head2", 8'hE1);
        pop_expect("t2_head3", 8'h7C);
        pop_expect("t2_head4", 8'hB4);
        check_eq("t2_empty", {31'd0, valid}, 32'd0);

        // Abort on the fifth read ack drops the partial byte.
        rd_base = rd_cnt;
        start_run(32'h0BAD_CAFE, 8'd0);
        n = 0;
        while (!(wb.ack && rd_ack_num == 5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t4_idle", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("t4_reads", rd_cnt - rd_base, 32'd5);
        check_eq("t4_fifo", {31'd0, valid}, 32'd0);
        check_eq("t4_cyc", {31'd0, wb.cyc}, 32'd0);
        // Start and abort together in IDLE: start wins.
        rd_base = rd_cnt;
        seed = 32'h0000_0001; count = 8'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("t4_start_wins", {31'd0, busy}, 32'd1);
        wait_idle("t4_idle2", 200);
        check_eq("t4_reads2", rd_cnt - rd_base, 32'd8);
        pop_expect("t4_byte", 8'hB4);

        // Asynchronous reset in the middle of a read.
        rd_base = rd_cnt;
        start_run(32'h5555_AAAA, 8'd0);
        n = 0;
        while (!((rd_cnt - rd_base) >= 12 && wb.cyc) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_prevalid", {31'd0, valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_cyc", {31'd0, wb.cyc}, 32'd0);
        check_eq("t6_stb", {31'd0, wb.stb}, 32'd0);
        check_eq("t6_valid", {31'd0, valid}, 32'd0);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t6_valid_after", {31'd0, valid}, 32'd0);
        check_eq("t6_busy_after", {31'd0, busy}, 32'd0);

`ifdef WB_LFSR_MASTER_TIMEOUT_EN
        // Slave never acks: bus is dropped after the timeout and o_err latches.
        no_ack = 1'b1;
        start_run(32'h0, 8'd1);
        n = 0; cyc_hi = 0;
        while (busy && n < 100) begin
            if (wb.cyc) cyc_hi++;
            @(negedge clk);
            n++;
        end
        check_eq("t5_cyc_cycles", cyc_hi, 32'd15);
        check_eq("t5_err", {31'd0, err}, 32'd1);
        check_eq("t5_idle", {31'd0, busy}, 32'd0);
        no_ack = 1'b0;
        rd_base = rd_cnt;
        start_run(32'h1, 8'd1);
        check_eq("t5_err_clr", {31'd0, err}, 32'd0);
        wait_idle("t5_idle2", 200);
        pop_expect("t5_byte", 8'hB4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
